// File: rtl/checker_window_ctrl_pkg.sv
// Shared types and constants for the character checker run controller.
// Provides the FSM state encoding and the checker clear duration.
package checker_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        LOCK  = 3'd2,
        RUN   = 3'd3,
        SNAP  = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int CLEAR_CYCLES = 2;

endpackage

// File: rtl/checker_window_ctrl_if.sv
// Bundle between the run controller, its sequencer and one checker.
// master: sequencer/checker side; slave: controller side.
interface checker_window_ctrl_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_W      = 32
);
    logic                    start;
    logic                    abort;
    logic [CNT_W-1:0]        window_len;
    logic [CNT_W-1:0]        err_threshold;
    logic [DATA_WIDTH-1:0]   data_in;
    logic [DATA_WIDTH/8-1:0] ctrl_in;
    logic [CNT_W-1:0]        chk_total;
    logic [CNT_W-1:0]        chk_data_err;
    logic [CNT_W-1:0]        chk_ctrl_err;
    logic                    chk_rst_n;
    logic                    busy;
    logic                    done;
    logic                    pass;
    logic                    lock_fail;
    logic                    aborted;
    logic [CNT_W-1:0]        snap_total;
    logic [CNT_W-1:0]        snap_data_err;
    logic [CNT_W-1:0]        snap_ctrl_err;
    logic [2:0]              state_o;

    modport master (
        output start, abort, window_len, err_threshold,
        output data_in, ctrl_in,
        output chk_total, chk_data_err, chk_ctrl_err,
        input  chk_rst_n, busy, done, pass, lock_fail, aborted,
        input  snap_total, snap_data_err, snap_ctrl_err, state_o
    );

    modport slave (
        input  start, abort, window_len, err_threshold,
        input  data_in, ctrl_in,
        input  chk_total, chk_data_err, chk_ctrl_err,
        output chk_rst_n, busy, done, pass, lock_fail, aborted,
        output snap_total, snap_data_err, snap_ctrl_err, state_o
    );

endinterface

// File: rtl/checker_window_ctrl.sv
// Run controller: clears the checker, waits for link lock, times a window,
// snapshots counters and grades pass/fail. Ports: clk, rst, bus (slave).
module checker_window_ctrl
    import checker_pkg::*;
#(
    parameter int DATA_WIDTH   = 64,
    parameter int CNT_W        = 32,
    parameter int LOCK_CYCLES  = 4,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    checker_window_ctrl_if.slave  bus
);

    localparam int LKW = $clog2(LOCK_CYCLES + 1);
    localparam int TOW = $clog2(LOCK_TIMEOUT + 1);

    state_t           state_q, state_d;
    logic [1:0]       clr_q, clr_d;
    logic [LKW-1:0]   lk_q, lk_d;
    logic [TOW-1:0]   to_q, to_d;
    logic [CNT_W-1:0] win_q, win_d;
    logic [CNT_W-1:0] wlen_q, wlen_d;
    logic [CNT_W-1:0] thr_q, thr_d;
    logic [CNT_W-1:0] st_q, st_d;
    logic [CNT_W-1:0] sd_q, sd_d;
    logic [CNT_W-1:0] sc_q, sc_d;
    logic             pass_q, pass_d;
    logic             lf_q, lf_d;
    logic             ab_q, ab_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             crn_q, crn_d;

    logic             active;
    logic [CNT_W:0]   err_sum;

    assign active  = (|bus.data_in) || (|bus.ctrl_in);
    // One extra bit so the error sum can never wrap below the threshold
    assign err_sum = {1'b0, bus.chk_data_err} + {1'b0, bus.chk_ctrl_err};

    always_comb begin
        state_d = state_q;
        clr_d   = clr_q;
        lk_d    = lk_q;
        to_d    = to_q;
        win_d   = win_q;
        wlen_d  = wlen_q;
        thr_d   = thr_q;
        st_d    = st_q;
        sd_d    = sd_q;
        sc_d    = sc_q;
        pass_d  = pass_q;
        lf_d    = lf_q;
        ab_d    = 1'b0;
        if (state_q != IDLE && bus.abort) begin
            state_d = IDLE;
            ab_d    = 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        wlen_d  = (bus.window_len == '0) ? CNT_W'(1)
                                                         : bus.window_len;
                        thr_d   = bus.err_threshold;
                        clr_d   = 2'd0;
                        state_d = CLEAR;
                    end
                end
                CLEAR: begin
                    if (clr_q == 2'(CLEAR_CYCLES - 1)) begin
                        lk_d    = '0;
                        to_d    = '0;
                        state_d = LOCK;
                    end else begin
                        clr_d = clr_q + 2'd1;
                    end
                end
                LOCK: begin
                    to_d = to_q + TOW'(1);
                    lk_d = active ? lk_q + LKW'(1) : '0;
                    // Lock takes precedence over a coincident timeout
                    if (active && lk_q == LKW'(LOCK_CYCLES - 1)) begin
                        win_d   = wlen_q;
                        state_d = RUN;
                    end else if (to_q == TOW'(LOCK_TIMEOUT - 1)) begin
                        lf_d    = 1'b1;
                        pass_d  = 1'b0;
                        state_d = DONE;
                    end
                end
                RUN: begin
                    if (win_q == CNT_W'(1)) begin
                        state_d = SNAP;
                    end else begin
                        win_d = win_q - CNT_W'(1);
                    end
                end
                SNAP: begin
                    // Checker registers its last RUN update into this cycle
                    st_d    = bus.chk_total;
                    sd_d    = bus.chk_data_err;
                    sc_d    = bus.chk_ctrl_err;
                    pass_d  = (bus.chk_total != '0) &&
                              (err_sum <= {1'b0, thr_q});
                    lf_d    = 1'b0;
                    state_d = DONE;
                end
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
        crn_d  = (state_d != IDLE) && (state_d != CLEAR);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            clr_q   <= '0;
            lk_q    <= '0;
            to_q    <= '0;
            win_q   <= '0;
            wlen_q  <= '0;
            thr_q   <= '0;
            st_q    <= '0;
            sd_q    <= '0;
            sc_q    <= '0;
            pass_q  <= 1'b0;
            lf_q    <= 1'b0;
            ab_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            crn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
            lk_q    <= lk_d;
            to_q    <= to_d;
            win_q   <= win_d;
            wlen_q  <= wlen_d;
            thr_q   <= thr_d;
            st_q    <= st_d;
            sd_q    <= sd_d;
            sc_q    <= sc_d;
            pass_q  <= pass_d;
            lf_q    <= lf_d;
            ab_q    <= ab_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            crn_q   <= crn_d;
        end
    end

    assign bus.chk_rst_n     = crn_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pass          = pass_q;
    assign bus.lock_fail     = lf_q;
    assign bus.aborted       = ab_q;
    assign bus.snap_total    = st_q;
    assign bus.snap_data_err = sd_q;
    assign bus.snap_ctrl_err = sc_q;
    assign bus.state_o       = state_q;

endmodule
